ivector_queue: RTL and testbench

- Parametrised successor to the single-entry say/heard echo vector.
- `say` requests (meth, v) are enqueued into a DEPTH-entry circular FIFO.
- A scheduler-controlled `respond` rule dequeues the head and drives the `ind_heard` indication with the stored fields.
- Adds a wrapping response counter, an occupancy output and a sticky overflow flag.
- Sits between a request source and an indication sink, under the rule_enable/rule_ready scheduling scheme.

---
 rtl/ivector_queue_if.sv | 24 ++
 rtl/ivector_queue.sv | 71 +++++++
 tb/tb_ivector_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ivector_queue_if.sv
// rtl/ivector_queue_if.sv - say request and heard indication handshake bundle for ivector_queue
interface ivector_queue_if #(
    parameter int METH_W = 6,
    parameter int V_W    = 4
);
    logic              say__ENA;
    logic [METH_W-1:0] say_meth;
    logic [V_W-1:0]    say_v;
    logic              say__RDY;
    logic              ind_heard__ENA;
    logic [METH_W-1:0] ind_heard_meth;
    logic [V_W-1:0]    ind_heard_v;
    logic              ind_heard__RDY;

    modport master (
        output say__ENA, say_meth, say_v, ind_heard__RDY,
        input  say__RDY, ind_heard__ENA, ind_heard_meth, ind_heard_v
    );

    modport slave (
        input  say__ENA, say_meth, say_v, ind_heard__RDY,
        output say__RDY, ind_heard__ENA, ind_heard_meth, ind_heard_v
    );
endinterface

// File: rtl/ivector_queue.sv
// rtl/ivector_queue.sv - DEPTH-entry say/heard echo FIFO with response counter and sticky overflow
module ivector_queue #(
    parameter int METH_W = 6,
    parameter int V_W    = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 15
) (
    input  logic                     CLK,
    input  logic                     nRST,
    ivector_queue_if.slave           bus,
    input  logic                     rule_enable,
    output logic                     rule_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         resp_count,
    output logic                     err_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [METH_W+V_W-1:0] mem [DEPTH];
    logic                  enq;
    logic                  fire;
    logic                  drop;

    // nRST gates the rule so a reset cycle never emits an indication
    always_comb begin
        bus.say__RDY       = (occupancy != FULL);
        rule_ready         = nRST & (occupancy != '0) & bus.ind_heard__RDY;
        fire               = rule_enable & rule_ready;
        enq                = bus.say__ENA & bus.say__RDY;
        drop               = bus.say__ENA & ~bus.say__RDY;
        bus.ind_heard__ENA = fire;
        {bus.ind_heard_meth, bus.ind_heard_v} = mem[rd_ptr];
    end

    always_ff @(posedge CLK) begin
        if (nRST && enq) begin
            mem[wr_ptr] <= {bus.say_meth, bus.say_v};
        end
    end

    // Power-of-two DEPTH lets the pointers wrap by natural overflow
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            resp_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr     <= rd_ptr + 1'b1;
                resp_count <= resp_count + 1'b1;
            end
            case ({enq, fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            if (drop) begin
                err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ivector_queue.sv
// tb/tb_ivector_queue.sv - vector table, directed corners and randomized model check for ivector_queue
module tb_ivector_queue;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       nrst;
    logic       say_ena;
    logic [5:0] say_meth;
    logic [3:0] say_v;
    logic       hrdy;
    logic       ren;

    logic       rr_m, rr_w, err_m, err_w;
    logic [2:0] occ_m, occ_w;
    logic [14:0] cnt_m;
    logic [2:0]  cnt_w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] mq[$];
    int         mcnt;
    bit         merr;
    bit         model_valid = 0;

    always #5 CLK = ~CLK;

    ivector_queue_if #(.METH_W(6), .V_W(4)) ifm ();
    ivector_queue_if #(.METH_W(6), .V_W(4)) ifw ();

    assign ifm.say__ENA = say_ena;
    assign ifm.say_meth = say_meth;
    assign ifm.say_v = say_v;
    assign ifm.ind_heard__RDY = hrdy;
    assign ifw.say__ENA = say_ena;
    assign ifw.say_meth = say_meth;
    assign ifw.say_v = say_v;
    assign ifw.ind_heard__RDY = hrdy;

    ivector_queue #(.METH_W(6), .V_W(4), .DEPTH(DEPTH), .CNT_W(15)) u_m (
        .CLK(CLK), .nRST(nrst), .bus(ifm.slave), .rule_enable(ren),
        .rule_ready(rr_m), .occupancy(occ_m), .resp_count(cnt_m), .err_overflow(err_m)
    );

    ivector_queue #(.METH_W(6), .V_W(4), .DEPTH(DEPTH), .CNT_W(3)) u_w (
        .CLK(CLK), .nRST(nrst), .bus(ifw.slave), .rule_enable(ren),
        .rule_ready(rr_w), .occupancy(occ_w), .resp_count(cnt_w), .err_overflow(err_w)
    );

    typedef struct {
        logic       ena;
        logic [5:0] meth;
        logic [3:0] v;
        logic       hrdy;
        logic       ren;
        logic       x_rdy;
        logic       x_rr;
        logic       x_ena;
        logic [5:0] x_meth;
        logic [3:0] x_v;
        int         x_occ;
        logic       x_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit [5:0] m, input bit [3:0] vv, input bit h, input bit r);
        say_ena = e;
        say_meth = m;
        say_v = vv;
        hrdy = h;
        ren = r;
    endtask

    task automatic step(input bit use_tbl, input int idx);
        bit x_rdy, x_rr, x_fire;
        @(negedge CLK);
        x_rdy = (mq.size() != DEPTH);
        x_rr = nrst && (mq.size() != 0) && hrdy;
        x_fire = x_rr && ren;
        if (model_valid) begin
            chk("say_rdy", 32'(ifm.say__RDY), 32'(x_rdy));
            chk("rule_ready", 32'(rr_m), 32'(x_rr));
            chk("ind_ena", 32'(ifm.ind_heard__ENA), 32'(x_fire));
            chk("occupancy", 32'(occ_m), 32'(mq.size()));
            chk("resp_count", 32'(cnt_m), 32'(mcnt % 32768));
            chk("resp_count_w3", 32'(cnt_w), 32'(mcnt % 8));
            chk("err_overflow", 32'(err_m), 32'(merr));
            if (x_fire) chk("ind_data", 32'({ifm.ind_heard_meth, ifm.ind_heard_v}), 32'(mq[0]));
        end
        if (use_tbl) begin
            chk("tbl_say_rdy", 32'(ifm.say__RDY), 32'(tbl[idx].x_rdy));
            chk("tbl_rule_ready", 32'(rr_m), 32'(tbl[idx].x_rr));
            chk("tbl_ind_ena", 32'(ifm.ind_heard__ENA), 32'(tbl[idx].x_ena));
            chk("tbl_occ", 32'(occ_m), 32'(tbl[idx].x_occ));
            chk("tbl_err", 32'(err_m), 32'(tbl[idx].x_err));
            if (tbl[idx].x_ena)
                chk("tbl_data", 32'({ifm.ind_heard_meth, ifm.ind_heard_v}),
                    32'({tbl[idx].x_meth, tbl[idx].x_v}));
        end
        if (!nrst) begin
            mq.delete();
            mcnt = 0;
            merr = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (say_ena && !x_rdy) merr = 1;
            if (x_fire) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (say_ena && x_rdy) mq.push_back({say_meth, say_v});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step(0, 0);
        nrst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 6'h2A, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0, 0, 1'b0};
        tbl[1]  = '{1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h2A, 4'h5, 1, 1'b0};
        tbl[2]  = '{1'b1, 6'h01, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0, 0, 1'b0};
        tbl[3]  = '{1'b1, 6'h02, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 4'h0, 1, 1'b0};
        tbl[4]  = '{1'b1, 6'h03, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 4'h0, 2, 1'b0};
        tbl[5]  = '{1'b1, 6'h04, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 4'h0, 3, 1'b0};
        tbl[6]  = '{1'b1, 6'h05, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 4'h0, 4, 1'b0};
        tbl[7]  = '{1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h01, 4'h1, 4, 1'b1};
        tbl[8]  = '{1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h02, 4'h2, 3, 1'b1};
        tbl[9]  = '{1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h03, 4'h3, 2, 1'b1};
        tbl[10] = '{1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h04, 4'h4, 1, 1'b1};
        tbl[11] = '{1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0, 0, 1'b1};

        nrst = 1'b0;
        drive(0, 0, 0, 1, 0);
        #1;
        step(0, 0);
        step(0, 0);
        nrst = 1'b1;
        chk("rst_say_rdy", 32'(ifm.say__RDY), 32'd1);
        chk("rst_rule_ready", 32'(rr_m), 32'd0);
        chk("rst_occ", 32'(occ_m), 32'd0);
        chk("rst_count", 32'(cnt_m), 32'd0);
        chk("rst_err", 32'(err_m), 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ena, tbl[i].meth, tbl[i].v, tbl[i].hrdy, tbl[i].ren);
            step(1, i);
            if (i == 1) begin
                chk("single_count", 32'(cnt_m), 32'd1);
                chk("single_occ", 32'(occ_m), 32'd0);
            end
        end
        chk("fill_count", 32'(cnt_m), 32'd5);
        chk("fill_err_sticky", 32'(err_m), 32'd1);

        do_reset();
        drive(1, 6'h11, 4'h1, 1, 0); step(0, 0);
        drive(1, 6'h22, 4'h2, 1, 0); step(0, 0);
        chk("simul_pre_occ", 32'(occ_m), 32'd2);
        drive(1, 6'h07, 4'h7, 1, 1); step(0, 0);
        chk("simul_occ", 32'(occ_m), 32'd2);
        drive(0, 0, 0, 1, 1);
        step(0, 0);
        step(0, 0);
        chk("simul_drain_occ", 32'(occ_m), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 6'(i + 8), 4'(i + 3), 1, 1);
            step(0, 0);
        end
        drive(0, 0, 0, 1, 1);
        step(0, 0);
        step(0, 0);
        chk("wrap_occ", 32'(occ_m), 32'd0);
        chk("wrap_count", 32'(cnt_m), 32'd13);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 6'(i + 30), 4'(i + 9), 1, 0);
            step(0, 0);
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            chk("bp_occ", 32'(occ_m), 32'd3);
        end
        hrdy = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("bp_drain_occ", 32'(occ_m), 32'd0);
        chk("bp_count", 32'(cnt_m), 32'd3);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1, 6'(i), 4'(i), 1, 0); step(0, 0);
            drive(0, 0, 0, 1, 1); step(0, 0);
        end
        chk("wrap3_count", 32'(cnt_w), 32'd1);
        chk("wide_count", 32'(cnt_m), 32'd9);
        drive(1, 6'h3C, 4'hC, 1, 0); step(0, 0);
        drive(1, 6'h3D, 4'hD, 1, 0); step(0, 0);
        drive(1, 6'h3E, 4'hE, 1, 0); step(0, 0);
        drive(1, 6'h3F, 4'hF, 1, 0); step(0, 0);
        drive(1, 6'h01, 4'h1, 1, 0); step(0, 0);
        drive(0, 0, 0, 1, 1); step(0, 0);
        drive(0, 0, 0, 1, 1); step(0, 0);
        chk("midrst_pre_occ", 32'(occ_m), 32'd2);
        nrst = 1'b0;
        step(0, 0);
        nrst = 1'b1;
        drive(0, 0, 0, 1, 0);
        chk("midrst_occ", 32'(occ_m), 32'd0);
        chk("midrst_count", 32'(cnt_m), 32'd0);
        chk("midrst_err", 32'(err_m), 32'd0);
        chk("midrst_rdy", 32'(ifm.say__RDY), 32'd1);
        chk("midrst_rr", 32'(rr_m), 32'd0);

        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i % 200) < 100) ? 80 : 30;
            nrst = ($urandom_range(0, 149) != 0);
            drive(($urandom_range(0, 99) < bias), 6'($urandom), 4'($urandom),
                  ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 60));
            step(0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
